prio_event_encoder: RTL and testbench

- Parametrised, registered successor to the 8-input combinational priority encoder.
- Captures rising edges on N request lines into sticky pending bits and presents the highest-priority unmasked pending index on a valid/ready output.
- Clears each pending bit only when its index is accepted.
- Sits between raw event/interrupt sources and a consumer FSM that services one event at a time.

---
 rtl/prio_event_encoder.sv | 145 ++++++++++++++
 tb/tb_prio_event_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder.sv
// prio_event_encoder: registered priority event encoder.
// Captures rising edges on N request lines into sticky pending bits and
// presents one unmasked pending index at a time on a valid/ready output.
// A pending bit is cleared only when its index is accepted.
// Optional feature macro: PRIO_EVENT_ENCODER_ROUND_ROBIN_EN
//   undefined: fixed priority, highest set index wins.
//   defined:   downward round-robin scan starting at a pointer that moves
//              to just below each accepted index.
module prio_event_encoder #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic         y_valid,
    output logic [W-1:0] y,
    input  logic         y_ready,
    output logic         none,
    output logic [N-1:0] pending
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   req_q, req_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   y_q, y_d;

    logic [N-1:0]   eligible;
    logic [N-1:0]   clr;
    logic           accept;
    logic [W-1:0]   sel_idx;

    assign eligible = pending_q & ~mask;
    assign none     = ~|eligible;
    assign y_valid  = (state_q == S_PRESENT);
    assign y        = y_q;
    assign pending  = pending_q;
    assign accept   = y_valid && y_ready;

`ifdef PRIO_EVENT_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    // Downward scan from ptr with wrap; the first eligible bit reached wins.
    always_comb begin
        int           pos;
        logic [W-1:0] idx;
        sel_idx = '0;
        // Walk the scan order backwards so the earliest eligible hit is the
        // last one written.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr_q) - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            idx = W'(pos);
            if (eligible[idx]) begin
                sel_idx = idx;
            end
        end
    end

    // Move the pointer just below the accepted index, wrapping at 0.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (y_q == '0) ? W'(N - 1) : y_q - 1'b1;
        end
    end
`else
    // Fixed priority: ascending scan, so the highest eligible index is the
    // last one written.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                sel_idx = W'(i);
            end
        end
    end
`endif

    // Edge capture: new rising edges set pending bits; an accept clears one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        clr = '0;
        if (accept) begin
            clr[y_q] = 1'b1;
        end
        req_d     = req;
        // A set in the same cycle as a clear wins, so no edge is lost.
        pending_d = (pending_q & ~clr) | (req & ~req_q);
    end

    // Presentation FSM: latch an index, hold it stable until accepted.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        unique case (state_q)
            S_IDLE: begin
                if (eligible != '0) begin
                    y_d     = sel_idx;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // No retraction: mask changes and new events wait.
                if (y_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            pending_q <= '0;
            y_q       <= '0;
`ifdef PRIO_EVENT_ENCODER_ROUND_ROBIN_EN
            ptr_q     <= W'(N - 1);
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            y_q       <= y_d;
`ifdef PRIO_EVENT_ENCODER_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Self-checking bench for prio_event_encoder (N=8).
module tb_prio_event_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         y_valid;
    logic [W-1:0] y;
    logic         y_ready;
    logic         none;
    logic [N-1:0] pending;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    prio_event_encoder #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .mask    (mask),
        .y_valid (y_valid),
        .y       (y),
        .y_ready (y_ready),
        .none    (none),
        .pending (pending)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] mask;
        logic         rdy;
        logic         exp_valid;
        logic [W-1:0] exp_y;
        logic         exp_none;
        logic [N-1:0] exp_pend;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Apply inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] m, input logic rd);
        req     = r;
        mask    = m;
        y_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        reset = 1'b1;
        step(r, '0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic check_out(input string name, input logic v, input logic [W-1:0] yy,
                             input logic n, input logic [N-1:0] p);
        check({name, ".y_valid"}, 64'(y_valid), 64'(v));
        if (v) check({name, ".y"}, 64'(y), 64'(yy));
        check({name, ".none"}, 64'(none), 64'(n));
        check({name, ".pending"}, 64'(pending), 64'(p));
    endtask

    initial begin
        //              req    mask   rdy  v  y  none pend
        vecs[0]  = '{8'h20, 8'h00, 0, 0, 0, 0, 8'h20};
        vecs[1]  = '{8'h00, 8'h00, 0, 1, 5, 0, 8'h20};
        vecs[2]  = '{8'h00, 8'h00, 1, 0, 5, 1, 8'h00};
        vecs[3]  = '{8'h09, 8'h00, 1, 0, 5, 0, 8'h09};
        vecs[4]  = '{8'h09, 8'h00, 1, 1, 3, 0, 8'h09};
        vecs[5]  = '{8'h09, 8'h00, 1, 0, 3, 0, 8'h01};
        vecs[6]  = '{8'h09, 8'h00, 1, 1, 0, 0, 8'h01};
        vecs[7]  = '{8'h09, 8'h00, 1, 0, 0, 1, 8'h00};
        vecs[8]  = '{8'h00, 8'h00, 0, 0, 0, 1, 8'h00};
        vecs[9]  = '{8'hFF, 8'hFF, 0, 0, 0, 1, 8'hFF};
        vecs[10] = '{8'hFF, 8'hFF, 0, 0, 0, 1, 8'hFF};
        vecs[11] = '{8'hFF, 8'h00, 0, 1, 7, 0, 8'hFF};
        vecs[12] = '{8'hFF, 8'h00, 1, 0, 7, 0, 8'h7F};
        vecs[13] = '{8'h00, 8'h00, 0, 1, 6, 0, 8'h7F};

        reset = 1'b1; req = '0; mask = '0; y_ready = 1'b0;

        // Reset state.
        do_reset('0);
        check("rst.y_valid", 64'(y_valid), 64'd0);
        check("rst.y", 64'(y), 64'd0);
        check("rst.none", 64'(none), 64'd1);
        check("rst.pending", 64'(pending), 64'd0);

        // Table: single pulse, simultaneous edges, full mask then unmask.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].req, vecs[i].mask, vecs[i].rdy);
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_y,
                      vecs[i].exp_none, vecs[i].exp_pend);
        end

        // Hold y=6 for 10 cycles while req[7] rises and bit 6 is masked.
        do_reset('0);
        step(8'h40, 8'h00, 0);
        step(8'h00, 8'h00, 0);
        check_out("hold.pre", 1, 6, 0, 8'h40);
        for (int i = 0; i < 10; i++) begin
            step(8'hC0, 8'h40, 0);
            check($sformatf("hold%0d.y", i), 64'(y), 64'd6);
            check($sformatf("hold%0d.y_valid", i), 64'(y_valid), 64'd1);
        end
        step(8'hC0, 8'h40, 1);
        check_out("hold.acc", 0, 6, 0, 8'h80);
        step(8'hC0, 8'h40, 0);
        check_out("hold.next", 1, 7, 0, 8'h80);

        // Reset during an in-flight handshake drops the event.
        reset = 1'b1;
        step(8'h00, 8'h00, 1);
        reset = 1'b0;
        check_out("rst_mid", 0, 0, 1, 8'h00);
        step(8'h00, 8'h00, 0);
        check("rst_mid.after", 64'(y_valid), 64'd0);

        // Re-edge of bit 2 in the same cycle its accept clears it.
        step(8'h04, 8'h00, 0);
        step(8'h00, 8'h00, 0);
        check_out("reedge.pre", 1, 2, 0, 8'h04);
        step(8'h04, 8'h00, 1);
        check_out("reedge.acc", 0, 2, 0, 8'h04);
        step(8'h04, 8'h00, 1);
        check_out("reedge.again", 1, 2, 0, 8'h04);

        // req held high across reset release counts as an edge.
        do_reset(8'h02);
        check("held.rst_pend", 64'(pending), 64'd0);
        step(8'h02, 8'h00, 0);
        check("held.pend", 64'(pending), 64'h02);
        step(8'h02, 8'h00, 0);
        check_out("held.present", 1, 1, 0, 8'h02);

        // 0x81 held, y_ready tied high: 7 then 0; re-edge both: 7 then 0.
        do_reset('0);
        step(8'h81, 8'h00, 1);
        check("rr.pend", 64'(pending), 64'h81);
        for (int rep = 0; rep < 2; rep++) begin
            step(8'h81, 8'h00, 1);
            check_out($sformatf("rr%0d.first", rep), 1, 7, 0, 8'h81);
            step(8'h81, 8'h00, 1);
            check_out($sformatf("rr%0d.acc7", rep), 0, 7, 0, 8'h01);
            step(8'h81, 8'h00, 1);
            check_out($sformatf("rr%0d.second", rep), 1, 0, 0, 8'h01);
            step(8'h81, 8'h00, 1);
            check_out($sformatf("rr%0d.acc0", rep), 0, 0, 1, 8'h00);
            if (rep == 0) begin
                step(8'h00, 8'h00, 1);
                step(8'h81, 8'h00, 1);
                check("rr.repend", 64'(pending), 64'h81);
            end
        end

        // Bit 7 re-edges at its own accept while bit 0 is still pending.
        do_reset('0);
        step(8'h81, 8'h00, 0);
        step(8'h01, 8'h00, 0);
        check_out("pol.first", 1, 7, 0, 8'h81);
        step(8'h81, 8'h00, 1);
        check_out("pol.acc", 0, 7, 0, 8'h81);
        step(8'h81, 8'h00, 0);
`ifdef PRIO_EVENT_ENCODER_ROUND_ROBIN_EN
        check_out("pol.next", 1, 0, 0, 8'h81);
`else
        check_out("pol.next", 1, 7, 0, 8'h81);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
